// File: rtl/keyed_pattern_fsm_pkg.sv
// Shared types and helpers for keyed_pattern_fsm: state kinds, pattern symbol
// extraction and elaboration-time parameter legality.
package keyed_pattern_fsm_pkg;

    localparam int MAX_PAT_W = 256;
    localparam int MAX_SYM_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAIN  = 2'd1,
        ST_DECOY = 2'd2
    } state_kind_e;

    function automatic logic [MAX_SYM_W-1:0] sym_at(input logic [MAX_PAT_W-1:0] pattern,
                                                    input int k, input int sym_w);
        logic [MAX_PAT_W-1:0] shifted;
        logic [MAX_PAT_W-1:0] mask;
        shifted = pattern >> (k * sym_w);
        mask    = ~({MAX_PAT_W{1'b1}} << sym_w);
        return MAX_SYM_W'(shifted & mask);
    endfunction

    function automatic bit params_legal(input int in_w, input int seq_len, input int key_w,
                                        input int lock_stage, input int trig_thresh,
                                        input int out_w);
        return (in_w >= 1) && (in_w <= MAX_SYM_W) && (seq_len >= 2) &&
               (seq_len * in_w <= MAX_PAT_W) && (key_w >= 1) &&
               (lock_stage >= 1) && (lock_stage <= seq_len - 1) &&
               (trig_thresh >= 1) && (out_w >= 1);
    endfunction

endpackage

// File: rtl/keyed_pattern_fsm_sat_counter.sv
// kpf_sat_counter: falling-edge saturating up-counter with synchronous clear,
// used for both the match count and the wrong-key diversion count.
module kpf_sat_counter #(
    parameter int            W     = 8,
    parameter logic [W-1:0]  LIMIT = {W{1'b1}}
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: clear wins, increments stop at LIMIT
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(negedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/keyed_pattern_fsm.sv
// Key-locked pattern recognizer with decoy path and sticky wrong-key lockout.
// Optional KEYED_PATTERN_FSM_RELOCK_EN adds a relock input that clears lockout.
module keyed_pattern_fsm
    import keyed_pattern_fsm_pkg::*;
#(
    parameter int                     IN_W        = 5,
    parameter int                     SEQ_LEN     = 4,
    parameter logic [SEQ_LEN*IN_W-1:0] PATTERN    = {5'h08, 5'h1F, 5'h11, 5'h03},
    parameter int                     KEY_W       = 4,
    parameter logic [KEY_W-1:0]       KEY_VAL     = 4'hA,
    parameter int                     LOCK_STAGE  = 2,
    parameter int                     TRIG_THRESH = 5,
    parameter int                     OUT_W       = 8,
    localparam int                    STG_W       = $clog2(SEQ_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [IN_W-1:0]  din,
    input  logic [KEY_W-1:0] keyinput,
`ifdef KEYED_PATTERN_FSM_RELOCK_EN
    input  logic             relock,
`endif
    output logic             match,
    output logic             err,
    output logic             lockout,
    output logic [OUT_W-1:0] match_cnt,
    output logic [STG_W-1:0] stage,
    output logic             in_decoy
);
    localparam int WC_W = $clog2(TRIG_THRESH + 1);

    if (!params_legal(IN_W, SEQ_LEN, KEY_W, LOCK_STAGE, TRIG_THRESH, OUT_W)) begin : g_param_err
        $fatal(1, "keyed_pattern_fsm: illegal parameter combination");
    end

    logic [IN_W-1:0] pat_sym [SEQ_LEN];
    for (genvar g = 0; g < SEQ_LEN; g++) begin : g_sym
        assign pat_sym[g] = IN_W'(sym_at(MAX_PAT_W'(PATTERN), g, IN_W));
    end

    state_kind_e      kind_q, kind_d;
    logic [STG_W-1:0] idx_q, idx_d;
    logic             match_q, match_d;
    logic             err_q, err_d;
    logic             lock_q, lock_d;
    logic             match_inc_s, wrong_inc_s, wrong_clr_s;
    logic [WC_W-1:0]  wrong_cnt_s;
    logic [IN_W-1:0]  cur_sym_s;
    logic             sym_hit_s, first_hit_s, key_ok_s, last_s, at_lock_s, thresh_s;

    // symbol expected at the current stage
    always_comb begin
        cur_sym_s = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            cur_sym_s = cur_sym_s | ((idx_q == STG_W'(k)) ? pat_sym[k] : {IN_W{1'b0}});
        end
    end

    assign sym_hit_s   = (din == cur_sym_s);
    assign first_hit_s = (din == pat_sym[0]);
    assign key_ok_s    = (keyinput == KEY_VAL);
    assign last_s      = (idx_q == STG_W'(SEQ_LEN - 1));
    assign at_lock_s   = (idx_q == STG_W'(LOCK_STAGE));
    assign thresh_s    = (wrong_cnt_s == WC_W'(TRIG_THRESH - 1));

    // state register
    always_ff @(negedge clk) begin
        if (!rst) begin
            kind_q  <= ST_IDLE;
            idx_q   <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            kind_q  <= kind_d;
            idx_q   <= idx_d;
            match_q <= match_d;
            err_q   <= err_d;
            lock_q  <= lock_d;
        end
    end

    // next-state and pulse decode
    always_comb begin
        kind_d      = kind_q;
        idx_d       = idx_q;
        match_d     = 1'b0;
        err_d       = 1'b0;
        lock_d      = lock_q;
        match_inc_s = 1'b0;
        wrong_inc_s = 1'b0;
        wrong_clr_s = 1'b0;
        if (lock_q) begin
`ifdef KEYED_PATTERN_FSM_RELOCK_EN
            if (relock) begin
                lock_d      = 1'b0;
                wrong_clr_s = 1'b1;
                kind_d      = ST_IDLE;
                idx_d       = '0;
            end else if (din_valid) begin
                kind_d = ST_IDLE;
                idx_d  = '0;
            end else begin
                kind_d = kind_q;
            end
`else
            if (din_valid) begin
                kind_d = ST_IDLE;
                idx_d  = '0;
            end else begin
                kind_d = kind_q;
            end
`endif
        end else if (din_valid) begin
            case (kind_q)
                ST_IDLE: begin
                    if (first_hit_s) begin
                        kind_d = ST_MAIN;
                        idx_d  = STG_W'(1);
                    end else begin
                        kind_d = ST_IDLE;
                        idx_d  = '0;
                    end
                end
                ST_MAIN, ST_DECOY: begin
                    if (!sym_hit_s) begin
                        // only the first pattern symbol can restart a sequence
                        kind_d = first_hit_s ? ST_MAIN : ST_IDLE;
                        idx_d  = first_hit_s ? STG_W'(1) : STG_W'(0);
                    end else if ((kind_q == ST_MAIN) && at_lock_s && !key_ok_s) begin
                        wrong_inc_s = 1'b1;
                        if (thresh_s) begin
                            kind_d = ST_IDLE;
                            idx_d  = '0;
                            lock_d = 1'b1;
                        end else if (last_s) begin
                            kind_d = ST_IDLE;
                            idx_d  = '0;
                            err_d  = 1'b1;
                        end else begin
                            kind_d = ST_DECOY;
                            idx_d  = idx_q + STG_W'(1);
                        end
                    end else if (last_s) begin
                        kind_d      = ST_IDLE;
                        idx_d       = '0;
                        match_d     = (kind_q == ST_MAIN);
                        match_inc_s = (kind_q == ST_MAIN);
                        err_d       = (kind_q == ST_DECOY);
                    end else begin
                        kind_d = kind_q;
                        idx_d  = idx_q + STG_W'(1);
                    end
                end
                default: begin
                    kind_d = ST_IDLE;
                    idx_d  = '0;
                end
            endcase
        end else begin
            kind_d = kind_q;
        end
    end

    // outputs derived from the state register
    always_comb begin
        stage    = (kind_q == ST_IDLE) ? STG_W'(0) : idx_q;
        in_decoy = (kind_q == ST_DECOY);
    end

    assign match   = match_q;
    assign err     = err_q;
    assign lockout = lock_q;

    kpf_sat_counter #(.W(OUT_W), .LIMIT({OUT_W{1'b1}})) u_match_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (1'b0),
        .inc_i  (match_inc_s),
        .cnt_o  (match_cnt)
    );

    kpf_sat_counter #(.W(WC_W), .LIMIT(WC_W'(TRIG_THRESH))) u_wrong_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (wrong_clr_s),
        .inc_i  (wrong_inc_s),
        .cnt_o  (wrong_cnt_s)
    );
endmodule
